// File: rtl/cs_accumulate_resolve_pkg.sv
// Shared definitions for the carry-save accumulate/resolve block: FSM encoding and chunk-count helper.
package cs_accumulate_resolve_pkg;

    localparam logic [1:0] ST_ACCUM   = 2'd0;
    localparam logic [1:0] ST_RESOLVE = 2'd1;
    localparam logic [1:0] ST_OUT     = 2'd2;

    function automatic int unsigned nchunk(input int unsigned acc_w, input int unsigned chunk);
        return acc_w / chunk;
    endfunction

endpackage

// File: rtl/reducer_4_to_2.sv
// 4:2 carry-save compressor built from two full-adder rows; sum + 2*carry + 2^WIDTH*cout = w+x+y+z+cin.
module reducer_4_to_2 #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] w,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] z,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] carry,
    output logic             cout
);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] c1;
    logic [WIDTH-1:0] chain;

    // First row carries ripple exactly one position into the second row.
    assign s1    = w ^ x ^ y;
    assign c1    = (w & x) | (w & y) | (x & y);
    assign chain = {c1[WIDTH-2:0], cin};
    assign sum   = s1 ^ z ^ chain;
    assign carry = (s1 & z) | (s1 & chain) | (z & chain);
    assign cout  = c1[WIDTH-1];

endmodule

// File: rtl/cs_accumulate_resolve.sv
// Accumulates carry-save beats per group, then resolves to binary with a chunked multi-cycle CPA.
module cs_accumulate_resolve
    import cs_accumulate_resolve_pkg::*;
#(
    parameter int unsigned IN_W  = 8,
    parameter int unsigned ACC_W = 24,
    parameter int unsigned CHUNK = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_sum,
    input  logic [IN_W-1:0]  in_carry,
    input  logic             in_last,
    input  logic             clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic [CNT_W-1:0] out_count
);

    localparam int unsigned NCHUNK = nchunk(ACC_W, CHUNK);
    localparam int unsigned IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    if (ACC_W % CHUNK != 0) begin : g_bad_chunk
        $error("ACC_W must be a multiple of CHUNK");
    end
    if (IN_W > ACC_W) begin : g_bad_in_w
        $error("IN_W must not exceed ACC_W");
    end

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [ACC_W-1:0] acc_s;
    logic [ACC_W-1:0] acc_c;
    logic [CNT_W-1:0] count;
    logic [IDX_W-1:0] idx;
    logic             cy;

    logic             accept_c;
    logic             last_chunk_c;
    logic [CNT_W-1:0] count_inc_c;
    logic [ACC_W-1:0] cmp_w_c;
    logic [ACC_W-1:0] cmp_x_c;
    logic [ACC_W-1:0] cmp_sum_c;
    logic [ACC_W-1:0] cmp_carry_c;
    logic             cmp_cout_unused;
    logic [ACC_W-1:0] op_b_c;
    logic [CHUNK-1:0] a_chunk_c;
    logic [CHUNK-1:0] b_chunk_c;
    logic [CHUNK:0]   chunk_res_c;

    assign accept_c     = in_valid & in_ready;
    assign last_chunk_c = (idx == IDX_W'(NCHUNK - 1));
    assign count_inc_c  = (&count) ? count : count + CNT_W'(1);

    // A clear that coincides with a beat starts the new group from that beat alone.
    assign cmp_w_c = clear ? '0 : acc_s;
    assign cmp_x_c = clear ? '0 : (acc_c << 1);

    reducer_4_to_2 #(.WIDTH(ACC_W)) u_reducer (
        .w     (cmp_w_c),
        .x     (cmp_x_c),
        .y     (ACC_W'(in_sum)),
        .z     (ACC_W'(in_carry) << 1),
        .cin   (1'b0),
        .sum   (cmp_sum_c),
        .carry (cmp_carry_c),
        .cout  (cmp_cout_unused)
    );

    // Chunk select for the carry-propagate add; operands are frozen while resolving.
    assign op_b_c = acc_c << 1;
    always_comb begin
        a_chunk_c = '0;
        b_chunk_c = '0;
        for (int unsigned k = 0; k < NCHUNK; k++) begin
            if (idx == IDX_W'(k)) begin
                a_chunk_c = acc_s[k*CHUNK +: CHUNK];
                b_chunk_c = op_b_c[k*CHUNK +: CHUNK];
            end
        end
    end
    assign chunk_res_c = {1'b0, a_chunk_c} + {1'b0, b_chunk_c} + {{CHUNK{1'b0}}, cy};

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_ACCUM:   if (accept_c && in_last) state_nxt = ST_RESOLVE;
            ST_RESOLVE: if (last_chunk_c)        state_nxt = ST_OUT;
            ST_OUT:     if (out_ready)           state_nxt = ST_ACCUM;
            default:                             state_nxt = ST_ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_ACCUM;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_s     <= '0;
            acc_c     <= '0;
            count     <= '0;
            idx       <= '0;
            cy        <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
        end else begin
            in_ready  <= (state_nxt == ST_ACCUM);
            out_valid <= (state_nxt == ST_OUT);
            case (state)
                ST_ACCUM: begin
                    idx <= '0;
                    cy  <= 1'b0;
                    if (accept_c) begin
                        acc_s <= cmp_sum_c;
                        acc_c <= cmp_carry_c;
                        count <= clear ? CNT_W'(1) : count_inc_c;
                        if (in_last) out_count <= clear ? CNT_W'(1) : count_inc_c;
                    end else if (clear) begin
                        acc_s <= '0;
                        acc_c <= '0;
                        count <= '0;
                    end
                end
                ST_RESOLVE: begin
                    for (int unsigned k = 0; k < NCHUNK; k++) begin
                        if (idx == IDX_W'(k)) out_data[k*CHUNK +: CHUNK] <= chunk_res_c[CHUNK-1:0];
                    end
                    cy  <= chunk_res_c[CHUNK];
                    idx <= idx + IDX_W'(1);
                end
                ST_OUT: begin
                    if (out_ready) begin
                        acc_s <= '0;
                        acc_c <= '0;
                        count <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cs_accumulate_resolve.sv
// Directed, table-driven bench for cs_accumulate_resolve (24-bit default plus an 8-bit wrap instance).
module tb_cs_accumulate_resolve;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_sum;
    logic [7:0]  in_carry;
    logic        in_last;
    logic        clear;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_data;
    logic [7:0]  out_count;

    logic        in_ready8;
    logic        out_valid8;
    logic [7:0]  out_data8;
    logic [7:0]  out_count8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cs_accumulate_resolve dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_sum(in_sum), .in_carry(in_carry), .in_last(in_last), .clear(clear),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_count(out_count)
    );

    cs_accumulate_resolve #(.IN_W(8), .ACC_W(8), .CHUNK(8), .CNT_W(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready8),
        .in_sum(in_sum), .in_carry(in_carry), .in_last(in_last), .clear(clear),
        .out_valid(out_valid8), .out_ready(out_ready), .out_data(out_data8), .out_count(out_count8)
    );

    typedef struct {
        int          nbeats;
        logic [7:0]  s;
        logic [7:0]  c;
        logic [23:0] exp_data;
        logic [7:0]  exp_count;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic beat(input logic [7:0] s, input logic [7:0] c, input logic last, input logic clr);
        in_valid = 1'b1;
        in_sum   = s;
        in_carry = c;
        in_last  = last;
        clear    = clr;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        clear    = 1'b0;
    endtask

    // Cycles from the accepting edge until out_valid is seen; bounded.
    task automatic wait_result(output int lat);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("hs_out_valid", 32'(out_valid), 32'd0);
        check("hs_in_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic group(input string name, input int n, input logic [7:0] s, input logic [7:0] c,
                         input logic [23:0] exp_data, input logic [7:0] exp_count);
        int lat;
        for (int b = 0; b < n; b++) beat(s, c, (b == n - 1), 1'b0);
        wait_result(lat);
        check({name, "_latency"}, 32'(lat), 32'd3);
        check({name, "_data"}, 32'(out_data), 32'(exp_data));
        check({name, "_count"}, 32'(out_count), 32'(exp_count));
        check({name, "_in_ready"}, 32'(in_ready), 32'd0);
        handshake();
    endtask

    initial begin
        int lat;
        vecs[0] = '{1,   8'h05, 8'h03, 24'd11,     8'd1};
        vecs[1] = '{9,   8'hFF, 8'hFF, 24'd6885,   8'd9};
        vecs[2] = '{3,   8'h10, 8'h20, 24'd240,    8'd3};
        vecs[3] = '{2,   8'h80, 8'h7F, 24'd764,    8'd2};
        vecs[4] = '{300, 8'hFF, 8'hFF, 24'd229500, 8'd255};

        rst = 1'b1; in_valid = 1'b0; in_sum = '0; in_carry = '0;
        in_last = 1'b0; clear = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_count", 32'(out_count), 32'd0);
        rst = 1'b0;

        foreach (vecs[i])
            group($sformatf("vec%0d", i), vecs[i].nbeats, vecs[i].s, vecs[i].c,
                  vecs[i].exp_data, vecs[i].exp_count);

        // Backpressure: result holds, input stalled even with a pending beat.
        beat(8'h05, 8'h03, 1'b1, 1'b0);
        wait_result(lat);
        check("bp_latency", 32'(lat), 32'd3);
        in_valid = 1'b1; in_sum = 8'hAA; in_carry = 8'h55; in_last = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            check("bp_data", 32'(out_data), 32'd11);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0; in_last = 1'b0;
        handshake();
        group("bp_next", 1, 8'h02, 8'h01, 24'd4, 8'd1);

        // clear alone after three beats, then a fresh single beat.
        for (int k = 0; k < 3; k++) beat(8'h10, 8'h10, 1'b0, 1'b0);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        group("clr_alone", 1, 8'h02, 8'h01, 24'd4, 8'd1);

        // clear together with beat+last: only that beat is resolved.
        for (int k = 0; k < 2; k++) beat(8'h10, 8'h10, 1'b0, 1'b0);
        beat(8'h05, 8'h03, 1'b1, 1'b1);
        wait_result(lat);
        check("clr_beat_latency", 32'(lat), 32'd3);
        check("clr_beat_data", 32'(out_data), 32'd11);
        check("clr_beat_count", 32'(out_count), 32'd1);
        handshake();

        // Reset while resolving discards the group.
        beat(8'h05, 8'h03, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rstmid_out_valid", 32'(out_valid), 32'd0);
        check("rstmid_in_ready", 32'(in_ready), 32'd1);
        check("rstmid_out_data", 32'(out_data), 32'd0);
        group("rstmid_next", 1, 8'h02, 8'h01, 24'd4, 8'd1);

        // Wrap: both instances see the same two beats from reset.
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("wrap_rst_data8", 32'(out_data8), 32'd0);
        beat(8'hFF, 8'hFF, 1'b0, 1'b0);
        beat(8'hFF, 8'hFF, 1'b1, 1'b0);
        wait_result(lat);
        check("wrap_latency24", 32'(lat), 32'd3);
        check("wrap_data24", 32'(out_data), 32'd1530);
        check("wrap_valid8", 32'(out_valid8), 32'd1);
        check("wrap_data8", 32'(out_data8), 32'd250);
        check("wrap_count8", 32'(out_count8), 32'd2);
        handshake();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
